// File: rtl/adc_frame_pkg.sv
// Shared constants and state encoding for the ADC frame assembler.
// Frame layout: STATUS word, eight channel words, one reserved word.
package adc_frame_pkg;

   localparam int ADC_WORDS_PER_FRAME = 10;

   localparam int ADC_STATUS_IDX = 0;
   localparam int ADC_CH0_IDX    = 1;
   localparam int ADC_CH1_IDX    = 2;
   localparam int ADC_CH2_IDX    = 3;
   localparam int ADC_CH3_IDX    = 4;
   localparam int ADC_CH4_IDX    = 5;
   localparam int ADC_CH5_IDX    = 6;
   localparam int ADC_CH6_IDX    = 7;
   localparam int ADC_CH7_IDX    = 8;
   localparam int ADC_RSVD_IDX   = 9;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_FILL = 1'b1
   } asm_state_e;

endpackage

// File: rtl/adc_frame_asm_stats.sv
// Framing statistics: a wrapping frame counter plus saturating drop and
// discard counters, each advanced by a one-cycle strobe.
module adc_frame_asm_stats #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_inc,
   input  logic             drop_inc,
   input  logic             discard_inc,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] drop_count,
   output logic [CNT_W-1:0] discard_count
);

   logic [CNT_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic [CNT_W-1:0] discard_q, discard_d;

   // Error counters stick at all-ones so a long outage is never hidden by wrap.
   always_comb begin
      frame_d   = frame_q;
      drop_d    = drop_q;
      discard_d = discard_q;
      if (frame_inc)
         frame_d = frame_q + CNT_W'(1);
      if (drop_inc && (drop_q != '1))
         drop_d = drop_q + CNT_W'(1);
      if (discard_inc && (discard_q != '1))
         discard_d = discard_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q   <= '0;
         drop_q    <= '0;
         discard_q <= '0;
      end else begin
         frame_q   <= frame_d;
         drop_q    <= drop_d;
         discard_q <= discard_d;
      end
   end

   assign frame_count   = frame_q;
   assign drop_count    = drop_q;
   assign discard_count = discard_q;

endmodule

// File: rtl/adc_frame_assembler.sv
// Aligns the ADC word stream on start-of-frame markers and hands complete
// frames downstream. Counters exist only when ADC_FRAME_ASM_STATS_EN is defined.
module adc_frame_assembler
   import adc_frame_pkg::*;
#(
   parameter int WORDS_PER_FRAME = ADC_WORDS_PER_FRAME,
   parameter int CNT_W           = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  in_word,
   input  logic                         in_sof,
   output logic                         frame_valid,
   input  logic                         frame_ready,
   output logic [32*WORDS_PER_FRAME-1:0] frame_words_packed,
   output logic [CNT_W-1:0]             frame_count,
   output logic [CNT_W-1:0]             drop_count,
   output logic [CNT_W-1:0]             discard_count
);

   localparam int IDX_W = $clog2(WORDS_PER_FRAME);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

   asm_state_e                     state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [32*WORDS_PER_FRAME-1:0]  work_q, work_d;
   logic [32*WORDS_PER_FRAME-1:0]  out_q, out_d;
   logic                           frame_valid_q, frame_valid_d;
   logic                           slot_busy, accept, consume;
   logic                           complete, drop, discard;

   // Only the word that would complete a frame must wait for a free output slot.
   assign slot_busy = frame_valid_q && !frame_ready;
   assign in_ready  = (state_q == ST_HUNT) || !((idx_q == LAST_IDX) && slot_busy);
   assign accept    = in_valid && in_ready;
   assign consume   = frame_valid_q && frame_ready;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      work_d   = work_q;
      out_d    = out_q;
      complete = 1'b0;
      drop     = 1'b0;
      discard  = 1'b0;
      if (accept) begin
         if (in_sof) begin
            work_d[31:0] = in_word;
            idx_d        = IDX_W'(1);
            drop         = (state_q == ST_FILL);
            state_d      = ST_FILL;
         end else if (state_q == ST_HUNT) begin
            discard = 1'b1;
         end else begin
            work_d[32*idx_q +: 32] = in_word;
            if (idx_q == LAST_IDX) begin
               complete = 1'b1;
               out_d    = work_d;
               idx_d    = '0;
               state_d  = ST_HUNT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
      end
   end

   // A completion wins over a same-edge consumption so the slot stays full.
   always_comb begin
      frame_valid_d = frame_valid_q;
      if (complete)
         frame_valid_d = 1'b1;
      else if (consume)
         frame_valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_HUNT;
         idx_q         <= '0;
         work_q        <= '0;
         out_q         <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         work_q        <= work_d;
         out_q         <= out_d;
         frame_valid_q <= frame_valid_d;
      end
   end

   assign frame_valid        = frame_valid_q;
   assign frame_words_packed = out_q;

`ifdef ADC_FRAME_ASM_STATS_EN
   adc_frame_asm_stats #(
      .CNT_W(CNT_W)
   ) u_stats (
      .clk          (clk),
      .rst          (rst),
      .frame_inc    (complete),
      .drop_inc     (drop),
      .discard_inc  (discard),
      .frame_count  (frame_count),
      .drop_count   (drop_count),
      .discard_count(discard_count)
   );
`else
   logic unused_strobes;
   assign unused_strobes = ^{complete, drop, discard};
   assign frame_count    = '0;
   assign drop_count     = '0;
   assign discard_count  = '0;
`endif

endmodule

// File: tb/tb_adc_frame_assembler.sv
// Directed bench for adc_frame_assembler: a per-cycle vector table for the
// streaming cases plus hand-written backpressure and mid-frame reset sequences.
module tb_adc_frame_assembler;

   localparam int N     = 10;
   localparam int CNT_W = 16;
`ifdef ADC_FRAME_ASM_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_word;
   logic             in_sof;
   logic             frame_valid;
   logic             frame_ready;
   logic [32*N-1:0]  frame_words_packed;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] drop_count;
   logic [CNT_W-1:0] discard_count;

   int vectors;
   int miscompares;

   typedef struct {
      logic        v;
      logic        sof;
      logic [31:0] word;
      logic        fr;
      logic        exp_rdy;
      logic        exp_fv;
      logic        chk;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w9;
   } vec_t;

   vec_t vecs[$];

   adc_frame_assembler dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_word           (in_word),
      .in_sof            (in_sof),
      .frame_valid       (frame_valid),
      .frame_ready       (frame_ready),
      .frame_words_packed(frame_words_packed),
      .frame_count       (frame_count),
      .drop_count        (drop_count),
      .discard_count     (discard_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void addVec(input logic v, input logic sof, input logic [31:0] word,
                                  input logic fr, input logic rdy, input logic fv,
                                  input logic chk, input logic [31:0] w0,
                                  input logic [31:0] w1, input logic [31:0] w9);
      vec_t e;
      e.v = v; e.sof = sof; e.word = word; e.fr = fr;
      e.exp_rdy = rdy; e.exp_fv = fv; e.chk = chk;
      e.w0 = w0; e.w1 = w1; e.w9 = w9;
      vecs.push_back(e);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then let combinational outputs settle.
   task automatic applyStimulus(input logic v, input logic sof, input logic [31:0] word,
                                input logic fr);
      @(negedge clk);
      in_valid    = v;
      in_sof      = sof;
      in_word     = word;
      frame_ready = fr;
      #1;
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic checkFrame(input string name, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w9);
      checkOutput({name, " word0"}, frame_words_packed[0 +: 32], w0);
      checkOutput({name, " word1"}, frame_words_packed[32 +: 32], w1);
      checkOutput({name, " word9"}, frame_words_packed[32*9 +: 32], w9);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      // Clean frame with downstream always ready
      addVec(1, 1, 32'hA5A55A5A, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         addVec(1, 0, 32'(k), 1, 1, k == 9, k == 9, 32'hA5A55A5A, 32'h1, 32'h9);
      addVec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      // Three non-sof words while hunting, then a frame
      for (int k = 0; k < 3; k++)
         addVec(1, 0, 32'hDEAD0000 + 32'(k), 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 1, 32'hC0DE0000, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         addVec(1, 0, 32'h10 + 32'(k), 1, 1, k == 9, k == 9, 32'hC0DE0000, 32'h11, 32'h19);
      addVec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      // Partial frame aborted by a new sof
      addVec(1, 1, 32'hB0000000, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++)
         addVec(1, 0, 32'h20 + 32'(k), 1, 1, 0, 0, 0, 0, 0);
      addVec(1, 1, 32'hB1111111, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 9; k++)
         addVec(1, 0, 32'h30 + 32'(k), 1, 1, k == 9, k == 9, 32'hB1111111, 32'h31, 32'h39);
      addVec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

      rst         = 1'b1;
      in_valid    = 1'b0;
      in_sof      = 1'b0;
      in_word     = '0;
      frame_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
      checkOutput("reset word0", frame_words_packed[0 +: 32], 32'h0);
      checkOutput("reset frame_count", 32'(frame_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset in_ready", 32'(in_ready), 32'h1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].v, vecs[i].sof, vecs[i].word, vecs[i].fr);
         checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         stepEdge();
         checkOutput($sformatf("vec%0d frame_valid", i), 32'(frame_valid), 32'(vecs[i].exp_fv));
         if (vecs[i].chk)
            checkFrame($sformatf("vec%0d", i), vecs[i].w0, vecs[i].w1, vecs[i].w9);
      end
      checkOutput("table frame_count", 32'(frame_count), 32'(3 * STATS));
      checkOutput("table discard_count", 32'(discard_count), 32'(3 * STATS));
      checkOutput("table drop_count", 32'(drop_count), 32'(1 * STATS));

      // Backpressure: two frames back-to-back with downstream stalled
      applyStimulus(1, 1, 32'hD0D0D0D0, 0);
      stepEdge();
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(1, 0, 32'h40 + 32'(k), 0);
         stepEdge();
      end
      checkOutput("bp frameA valid", 32'(frame_valid), 32'h1);
      checkFrame("bp frameA", 32'hD0D0D0D0, 32'h41, 32'h49);
      applyStimulus(1, 1, 32'hE0E0E0E0, 0);
      checkOutput("bp frameB sof in_ready", 32'(in_ready), 32'h1);
      stepEdge();
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1, 0, 32'h50 + 32'(k), 0);
         stepEdge();
      end
      applyStimulus(1, 0, 32'h59, 0);
      checkOutput("bp stall in_ready", 32'(in_ready), 32'h0);
      stepEdge();
      checkOutput("bp stall in_ready held", 32'(in_ready), 32'h0);
      checkOutput("bp stall frame_valid", 32'(frame_valid), 32'h1);
      checkFrame("bp frameA held", 32'hD0D0D0D0, 32'h41, 32'h49);
      applyStimulus(1, 0, 32'h59, 1);
      checkOutput("bp release in_ready", 32'(in_ready), 32'h1);
      stepEdge();
      checkOutput("bp same-edge frame_valid", 32'(frame_valid), 32'h1);
      checkFrame("bp frameB", 32'hE0E0E0E0, 32'h51, 32'h59);
      checkOutput("bp frame_count", 32'(frame_count), 32'(5 * STATS));
      applyStimulus(0, 0, 0, 1);
      stepEdge();
      checkOutput("bp drained frame_valid", 32'(frame_valid), 32'h0);
      checkFrame("bp data kept", 32'hE0E0E0E0, 32'h51, 32'h59);

      // Reset in the middle of a frame
      applyStimulus(1, 1, 32'hF0F0F0F0, 1);
      stepEdge();
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1, 0, 32'h60 + 32'(k), 1);
         stepEdge();
      end
      applyStimulus(0, 0, 0, 1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid-reset frame_valid", 32'(frame_valid), 32'h0);
      checkFrame("mid-reset", 32'h0, 32'h0, 32'h0);
      checkOutput("mid-reset frame_count", 32'(frame_count), 32'h0);
      checkOutput("mid-reset discard_count", 32'(discard_count), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("post-reset in_ready", 32'(in_ready), 32'h1);
      applyStimulus(1, 1, 32'hA5A55A5A, 1);
      stepEdge();
      for (int k = 1; k <= 9; k++) begin
         applyStimulus(1, 0, 32'(k), 1);
         stepEdge();
         checkOutput($sformatf("post-reset w%0d frame_valid", k), 32'(frame_valid),
                     32'(k == 9));
      end
      checkFrame("post-reset frame", 32'hA5A55A5A, 32'h1, 32'h9);
      applyStimulus(0, 0, 0, 1);
      stepEdge();
      checkOutput("post-reset pulse end", 32'(frame_valid), 32'h0);
      checkOutput("post-reset frame_count", 32'(frame_count), 32'(1 * STATS));
      checkOutput("post-reset drop_count", 32'(drop_count), 32'h0);
      checkOutput("post-reset discard_count", 32'(discard_count), 32'h0);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adc_frame_assembler.md
# adc_frame_assembler

Sequential stage directly upstream of `adc_soc_frame_unpack`. It accepts the ADC capture path's 32-bit word stream under a valid/ready handshake and aligns it on start-of-frame markers. It collects `WORDS_PER_FRAME` words into a packed frame register and presents that register, with a valid/ready handshake, as `frame_words_packed` to the unpacker. Partial frames are dropped, and the block resynchronises on a start-of-frame marker.

## Interface
- `WORDS_PER_FRAME`, 10, words per frame: STATUS, CH0..CH7, then 1 reserved word; minimum 2.
- `CNT_W`, 16, width of the statistics counters.

- `clk`  in  1  sole clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_word`  in  32  stream word.
- `in_sof`  in  1  qualifies `in_word` as word 0 (STATUS) of a frame.
- `frame_valid`  out  1  `frame_words_packed` holds a complete frame.
- `frame_ready`  in  1  downstream consumes the frame.
- `frame_words_packed`  out  32*WORDS_PER_FRAME  word k at `[32*k +: 32]`.
- `frame_count`  out  CNT_W  completed frames; wraps.
- `drop_count`  out  CNT_W  partial frames aborted; saturates.
- `discard_count`  out  CNT_W  words discarded while hunting; saturates.

## Operation
- A word is accepted on a clock edge where `in_valid && in_ready`. A frame is consumed on an edge where `frame_valid && frame_ready`.
- States: HUNT and FILL, with a word index `idx` (0..N-1, where N = WORDS_PER_FRAME).
- HUNT:
  - Accepted word with `in_sof`=1: stored as word 0, `idx`←1, go to FILL.
  - Accepted word without sof: discarded, `discard_count`++.
  - `in_ready`=1 unconditionally.
- FILL:
  - Accepted word with `in_sof`=0: stored at `idx`, `idx`++.
  - Accepted word with `in_sof`=1: current partial frame abandoned, `drop_count`++. This word becomes word 0 and `idx`←1.
  - On accepting word N-1 (without sof): the whole frame is copied into the output register, `frame_valid`←1, `frame_count`++, go to HUNT.
- `in_ready` in FILL is 0 only when `idx`==N-1 and the output slot is busy. The slot is busy when `frame_valid`=1 and `frame_ready`=0. This is a combinational path from `frame_ready` to `in_ready`.
- Output register is written only on frame completion. It is held stable while `frame_valid && !frame_ready`.
- Completion and consumption on the same edge: the new frame is loaded and `frame_valid` stays 1.
- Consumption with no completion on that edge: `frame_valid`←0. The data is left unchanged.
- A word with sof at `idx`==N-1 while the output slot is busy is stalled, because `in_ready`=0. Once accepted, it aborts the partial frame as above.
- Counters: `drop_count` and `discard_count` stick at all-ones; `frame_count` wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous assert):
  - state←HUNT, `idx`←0.
  - `frame_valid`←0, `frame_words_packed`←0, all counters←0.
  - `in_ready`=1 as soon as `rst` is low.
- Reset mid-frame discards the partial frame and the held output frame; it does not count as a drop.
- Latency: `frame_valid` is high in the cycle after the edge that accepts word N-1.
- Throughput: one word per cycle. Back-to-back frames run with no bubble while `frame_ready` is held high (sof word accepted in HUNT the cycle after completion).

## Configuration
- `ADC_FRAME_ASM_STATS_EN` defined: the three counters are implemented as described above.
- Not defined: no counter flops are built; `frame_count`, `drop_count` and `discard_count` are tied to 0. Framing behaviour is identical in both builds.

## Structure
- Shared package `adc_frame_pkg` holds:
  - `ADC_WORDS_PER_FRAME` = 10.
  - Word-index constants: `ADC_STATUS_IDX`=0, `ADC_CH0_IDX`=1..`ADC_CH7_IDX`=8, `ADC_RSVD_IDX`=9.
  - The HUNT/FILL state enum.
- One sub-module: `adc_frame_asm_stats`, holding the three counters, with increment strobes in and counts out. It is instantiated only under `ADC_FRAME_ASM_STATS_EN`.

## Test plan
- Clean frame: word sequence 0xA5A55A5A (sof), then 0x1..0x9; `frame_ready`=1. Required: `frame_valid` pulses for 1 cycle, word0=0xA5A55A5A, word9=0x9, `frame_count`=1.
- Hunt: 3 words without sof, then a clean frame. Required: `discard_count`=3, frame content correct.
- Resync: sof plus 4 words, then sof plus 9 words. Required: `drop_count`=1, a single output frame containing the second frame's words.
- Backpressure: `frame_ready`=0 with two frames sent back-to-back. Required: first frame held stable, `in_ready`=0 at word 9 of the second frame. Raising `frame_ready` for 1 cycle gives a same-edge load of frame 2 with `frame_valid` staying 1.
- Reset mid-frame: `rst` pulse after word 5. Required: all outputs 0 and state HUNT; the next clean frame is output correctly with `drop_count`=0.
- Stats-off build: same stimulus as the resync test. Required: identical frames, all counters 0.
